// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file write-back controller.
//   REG_ADDR_W    : architectural register address width
//   WB_DATA_MAX_W : width of the data container in wb_req_t. Any XLEN up to
//                   this width fits; the top zero-extends into it and
//                   truncates back out.
//   gnt_e         : arbiter grant outcome
//   wb_req_t      : one write-back request (valid, addr, data)
package rf_ctrl_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int WB_DATA_MAX_W = 64;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_EX,
    GNT_LSU
  } gnt_e;

  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR_W-1:0]    addr;
    logic [WB_DATA_MAX_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arb.sv
// Two-requester write-back arbiter (EX, LSU) feeding one register-file port.
// At most one grant per cycle. The ready outputs are combinational from the
// valid inputs and, in round-robin mode, from the pointer.
//
// Build option RF_WB_RR_EN:
//   defined   : two-way round-robin. A one-bit pointer holds the last winner.
//               On a conflict the other requester wins. The pointer moves only
//               on a grant and resets to favour the LSU.
//   undefined : fixed priority with the LSU first. This mode has no state.
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   ex_valid_i    : EX request
//   lsu_valid_i   : LSU request
//   ex_ready_o    : EX granted this cycle
//   lsu_ready_o   : LSU granted this cycle
//   gnt_o         : grant outcome (GNT_NONE / GNT_EX / GNT_LSU)
module rf_wb_arb
  import rf_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic ex_valid_i,
  input  logic lsu_valid_i,
  output logic ex_ready_o,
  output logic lsu_ready_o,
  output gnt_e gnt_o
);

  logic lsu_win;
  logic ex_win;

`ifdef RF_WB_RR_EN
  // 1 = the LSU won the most recent grant. The reset value 0 makes the LSU
  // win the first conflict.
  logic last_lsu_q;

  always_comb begin
    lsu_win = lsu_valid_i & (~ex_valid_i | ~last_lsu_q);
    ex_win  = ex_valid_i & ~lsu_win;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_lsu_q <= 1'b0;
    end else if (lsu_win | ex_win) begin
      last_lsu_q <= lsu_win;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_i;

  always_comb begin
    lsu_win = lsu_valid_i;
    ex_win  = ex_valid_i & ~lsu_valid_i;
  end
`endif

  assign lsu_ready_o = lsu_win;
  assign ex_ready_o  = ex_win;

  always_comb begin
    gnt_o = GNT_NONE;
    if (lsu_win)     gnt_o = GNT_LSU;
    else if (ex_win) gnt_o = GNT_EX;
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller and scoreboard.
//
// The block arbitrates the EX and LSU write-back requests onto the single
// register-file write port. It keeps one busy bit per architectural register,
// from issue until the register-file write, and stalls decode on RAW and WAW
// hazards.
//
// Build option RF_WB_RR_EN selects round-robin arbitration. The default is
// fixed priority with the LSU first. See rf_wb_arb.
//
// Parameters:
//   XLEN    : data width, at most WB_DATA_MAX_W
//   REG_NUM : number of architectural registers
//
// Ports:
//   clk_i, rst_i                           : clock, synchronous active-high reset
//   issue_valid_i                          : decode wants to issue this cycle
//   issue_rd_we_i, issue_rd_addr_i         : the issuing instruction's rd
//   rs1/rs2_addr_i, rs1/rs2_used_i         : source registers read by decode
//   stall_o                                : hold decode (RAW or WAW)
//   ex_valid_i/rd_addr_i/rd_data_i, ex_ready_o    : EX write-back handshake
//   lsu_valid_i/rd_addr_i/rd_data_i, lsu_ready_o  : LSU write-back handshake
//   rd_we_o, rd_addr_o, rd_data_o          : registered register-file write port
//   busy_o                                 : scoreboard bits
module rf_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_rd_we_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  output logic                  stall_o,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic [XLEN-1:0]       ex_rd_data_i,
  output logic                  ex_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_addr_i,
  input  logic [XLEN-1:0]       lsu_rd_data_i,
  output logic                  lsu_ready_o,
  output logic                  rd_we_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic [REG_NUM-1:0]    busy_o
);

  gnt_e                  gnt;
  wb_req_t               win_p0;
  logic                  wb_we_p1;
  logic [REG_ADDR_W-1:0] wb_addr_p1;
  logic [XLEN-1:0]       wb_data_p1;
  logic [REG_NUM-1:0]    busy_q;
  logic [REG_NUM-1:0]    busy_d;
  logic                  raw;
  logic                  waw;
  logic                  issue_fire;

  rf_wb_arb u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ex_valid_i  (ex_valid_i),
    .lsu_valid_i (lsu_valid_i),
    .ex_ready_o  (ex_ready_o),
    .lsu_ready_o (lsu_ready_o),
    .gnt_o       (gnt)
  );

  always_comb begin
    win_p0 = '0;
    unique case (gnt)
      GNT_LSU: begin
        win_p0.valid = 1'b1;
        win_p0.addr  = lsu_rd_addr_i;
        win_p0.data  = WB_DATA_MAX_W'(lsu_rd_data_i);
      end
      GNT_EX: begin
        win_p0.valid = 1'b1;
        win_p0.addr  = ex_rd_addr_i;
        win_p0.data  = WB_DATA_MAX_W'(ex_rd_data_i);
      end
      default: ;
    endcase
  end

  // ---- p0 -> p1: register-file write port ----
  // A grant to x0 still consumes the request. The write enable stays low, so
  // the write is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_we_p1   <= 1'b0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
    end else if (win_p0.valid) begin
      wb_we_p1   <= (win_p0.addr != '0);
      wb_addr_p1 <= win_p0.addr;
      wb_data_p1 <= win_p0.data[XLEN-1:0];
    end else begin
      wb_we_p1   <= 1'b0;
    end
  end

  // Every hazard term reads the registered busy bits. A register stays busy
  // through the cycle in which the register file writes it, so a dependent
  // read never needs a bypass path.
  always_comb begin
    raw        = (rs1_used_i & busy_q[rs1_addr_i]) | (rs2_used_i & busy_q[rs2_addr_i]);
    waw        = issue_rd_we_i & busy_q[issue_rd_addr_i];
    stall_o    = issue_valid_i & (raw | waw);
    issue_fire = issue_valid_i & ~stall_o & issue_rd_we_i & (issue_rd_addr_i != '0);
  end

  // The set is applied after the clear, so a new issue to the register being
  // written keeps that register busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_we_p1)   busy_d[wb_addr_p1]      = 1'b0;
    if (issue_fire) busy_d[issue_rd_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign rd_we_o   = wb_we_p1;
  assign rd_addr_o = wb_addr_p1;
  assign rd_data_o = wb_data_p1;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
module tb_rf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_rd_we_i;
  logic [4:0]  issue_rd_addr_i, rs1_addr_i, rs2_addr_i;
  logic        rs1_used_i, rs2_used_i;
  logic        stall_o;
  logic        ex_valid_i;
  logic [4:0]  ex_rd_addr_i;
  logic [31:0] ex_rd_data_i;
  logic        ex_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_rd_data_i;
  logic        lsu_ready_o;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [31:0] busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_wb_ctrl #(.XLEN(32), .REG_NUM(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_we_i   (issue_rd_we_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .rs1_used_i      (rs1_used_i),
    .rs2_used_i      (rs2_used_i),
    .stall_o         (stall_o),
    .ex_valid_i      (ex_valid_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .ex_rd_data_i    (ex_rd_data_i),
    .ex_ready_o      (ex_ready_o),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_rd_addr_i   (lsu_rd_addr_i),
    .lsu_rd_data_i   (lsu_rd_data_i),
    .lsu_ready_o     (lsu_ready_o),
    .rd_we_o         (rd_we_o),
    .rd_addr_o       (rd_addr_o),
    .rd_data_o       (rd_data_o),
    .busy_o          (busy_o)
  );

  // Advance one clock. Registered outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after the inputs change.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 0; issue_rd_we_i = 0; issue_rd_addr_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rs1_used_i = 0; rs2_used_i = 0;
    ex_valid_i = 0; ex_rd_addr_i = 0; ex_rd_data_i = 0;
    lsu_valid_i = 0; lsu_rd_addr_i = 0; lsu_rd_data_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
    settle();
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL reset_busy got=%h exp=%h", busy_o, 32'h0); end
    tests++; if (rd_we_o !== 1'b0) begin fails++; $display("FAIL reset_we got=%b exp=0", rd_we_o); end
    tests++; if (rd_addr_o !== 5'd0 || rd_data_o !== 32'h0) begin fails++; $display("FAIL reset_addr_data got=%0d/%h exp=0/0", rd_addr_o, rd_data_o); end
    tests++; if (stall_o !== 1'b0 || ex_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin fails++; $display("FAIL reset_comb got=%b%b%b exp=000", stall_o, ex_ready_o, lsu_ready_o); end
  endtask

  task automatic test_basic_write();
    ex_valid_i = 1; ex_rd_addr_i = 5; ex_rd_data_i = 32'hDEADBEEF;
    settle();
    tests++; if (ex_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin fails++; $display("FAIL basic_ready got ex=%b lsu=%b exp ex=1 lsu=0", ex_ready_o, lsu_ready_o); end
    tick();
    ex_valid_i = 0;
    settle();
    tests++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_write got we=%b addr=%0d data=%h exp we=1 addr=5 data=deadbeef", rd_we_o, rd_addr_o, rd_data_o); end
    tick();
    tests++; if (rd_we_o !== 1'b0 || rd_addr_o !== 5'd5 || rd_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_hold got we=%b addr=%0d data=%h exp we=0 addr=5 data=deadbeef", rd_we_o, rd_addr_o, rd_data_o); end
  endtask

  task automatic test_conflict();
    ex_valid_i = 1;  ex_rd_addr_i = 3;  ex_rd_data_i = 32'h11;
    lsu_valid_i = 1; lsu_rd_addr_i = 4; lsu_rd_data_i = 32'h22;
    settle();
    tests++; if (lsu_ready_o !== 1'b1 || ex_ready_o !== 1'b0) begin fails++; $display("FAIL conflict_first_gnt got ex=%b lsu=%b exp ex=0 lsu=1", ex_ready_o, lsu_ready_o); end
`ifdef RF_WB_RR_EN
    // Both requesters stay valid, so the grants alternate LSU, EX, LSU.
    tick();
    tests++; if (rd_addr_o !== 5'd4 || rd_data_o !== 32'h22 || ex_ready_o !== 1'b1) begin fails++; $display("FAIL rr_second got addr=%0d data=%h ex_rdy=%b exp addr=4 data=22 ex_rdy=1", rd_addr_o, rd_data_o, ex_ready_o); end
    tick();
    tests++; if (rd_addr_o !== 5'd3 || rd_data_o !== 32'h11 || lsu_ready_o !== 1'b1) begin fails++; $display("FAIL rr_third got addr=%0d data=%h lsu_rdy=%b exp addr=3 data=11 lsu_rdy=1", rd_addr_o, rd_data_o, lsu_ready_o); end
    tick();
    ex_valid_i = 0; lsu_valid_i = 0;
    tests++; if (rd_addr_o !== 5'd4 || rd_we_o !== 1'b1) begin fails++; $display("FAIL rr_fourth got addr=%0d we=%b exp addr=4 we=1", rd_addr_o, rd_we_o); end
`else
    tick();
    lsu_valid_i = 0;
    settle();
    tests++; if (rd_addr_o !== 5'd4 || rd_data_o !== 32'h22 || ex_ready_o !== 1'b1) begin fails++; $display("FAIL conflict_lsu_first got addr=%0d data=%h ex_rdy=%b exp addr=4 data=22 ex_rdy=1", rd_addr_o, rd_data_o, ex_ready_o); end
    tick();
    ex_valid_i = 0;
    tests++; if (rd_addr_o !== 5'd3 || rd_data_o !== 32'h11 || rd_we_o !== 1'b1) begin fails++; $display("FAIL conflict_ex_second got addr=%0d data=%h we=%b exp addr=3 data=11 we=1", rd_addr_o, rd_data_o, rd_we_o); end
`endif
    tick();
  endtask

  task automatic test_raw();
    issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 7;
    settle();
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL raw_issue_stall got=%b exp=0", stall_o); end
    tick();
    issue_valid_i = 0; issue_rd_we_i = 0;
    tests++; if (busy_o !== 32'h0000_0080) begin fails++; $display("FAIL raw_busy_set got=%h exp=00000080", busy_o); end
    // A second write to x7 while it is busy is a WAW hazard.
    issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 7;
    settle();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL waw_stall got=%b exp=1", stall_o); end
    // The instruction in decode reads x7, and the write-back is granted in cycle N.
    issue_rd_we_i = 0; issue_rd_addr_i = 0; rs1_addr_i = 7; rs1_used_i = 1;
    ex_valid_i = 1; ex_rd_addr_i = 7; ex_rd_data_i = 32'h77;
    settle();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL raw_stall_N got=%b exp=1", stall_o); end
    tick();
    ex_valid_i = 0;
    settle();
    tests++; if (stall_o !== 1'b1 || rd_we_o !== 1'b1) begin fails++; $display("FAIL raw_stall_N1 got stall=%b we=%b exp stall=1 we=1", stall_o, rd_we_o); end
    tick();
    tests++; if (stall_o !== 1'b0 || busy_o !== 32'h0) begin fails++; $display("FAIL raw_release_N2 got stall=%b busy=%h exp stall=0 busy=0", stall_o, busy_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 0;
    tick();
    issue_valid_i = 0; issue_rd_we_i = 0;
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL x0_busy got=%h exp=0", busy_o); end
    ex_valid_i = 1; ex_rd_addr_i = 0; ex_rd_data_i = 32'hAB;
    settle();
    tests++; if (ex_ready_o !== 1'b1) begin fails++; $display("FAIL x0_ready got=%b exp=1", ex_ready_o); end
    tick();
    ex_valid_i = 0;
    tests++; if (rd_we_o !== 1'b0) begin fails++; $display("FAIL x0_we got=%b exp=0", rd_we_o); end
    tick();
  endtask

  task automatic test_set_clear();
    // x9 is not busy. The write-back to x9 lands in the same cycle that a new
    // issue sets x9.
    ex_valid_i = 1; ex_rd_addr_i = 9; ex_rd_data_i = 32'h99;
    tick();
    ex_valid_i = 0;
    issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 9;
    settle();
    tests++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd9 || stall_o !== 1'b0) begin fails++; $display("FAIL setclr_pre got we=%b addr=%0d stall=%b exp we=1 addr=9 stall=0", rd_we_o, rd_addr_o, stall_o); end
    tick();
    issue_valid_i = 0; issue_rd_we_i = 0;
    tests++; if (busy_o !== 32'h0000_0200) begin fails++; $display("FAIL setclr_busy got=%h exp=00000200", busy_o); end
  endtask

  task automatic test_reset_mid();
    issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 8;
    ex_valid_i = 1; ex_rd_addr_i = 5; ex_rd_data_i = 32'h55;
    tick();
    idle_inputs();
    tests++; if (busy_o !== 32'h0000_0300 || rd_we_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre got busy=%h we=%b exp busy=00000300 we=1", busy_o, rd_we_o); end
    rst_i = 1;
    tick();
    rst_i = 0;
    issue_valid_i = 1; rs1_addr_i = 9; rs1_used_i = 1;
    settle();
    tests++; if (busy_o !== 32'h0 || rd_we_o !== 1'b0 || rd_addr_o !== 5'd0 || rd_data_o !== 32'h0) begin fails++; $display("FAIL rstmid_regs got busy=%h we=%b addr=%0d data=%h exp all 0", busy_o, rd_we_o, rd_addr_o, rd_data_o); end
    tests++; if (stall_o !== 1'b0 || ex_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin fails++; $display("FAIL rstmid_comb got stall=%b ex=%b lsu=%b exp 0 0 0", stall_o, ex_ready_o, lsu_ready_o); end
    idle_inputs();
    // A request held through reset is dropped and then granted again.
    ex_valid_i = 1; ex_rd_addr_i = 6; ex_rd_data_i = 32'h66;
    rst_i = 1;
    tick();
    rst_i = 0;
    settle();
    tests++; if (rd_we_o !== 1'b0 || ex_ready_o !== 1'b1) begin fails++; $display("FAIL rst_drop got we=%b ex_rdy=%b exp we=0 ex_rdy=1", rd_we_o, ex_ready_o); end
    tick();
    ex_valid_i = 0;
    tests++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd6 || rd_data_o !== 32'h66) begin fails++; $display("FAIL rst_regrant got we=%b addr=%0d data=%h exp we=1 addr=6 data=66", rd_we_o, rd_addr_o, rd_data_o); end
    tick();
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_basic_write();
    test_conflict();
    test_raw();
    test_x0();
    test_set_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
